spi_target_sync: RTL

SPI_TARGET_SYNC -- requirements
Module: spi_target_sync

---
 rtl/spi_target_sync_if.sv | 35 +++
 rtl/spi_target_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_target_sync_if                                           |
// | Description : SPI pin and byte-stream bundle for the SPI target.           |
// |               The slave modport is the target's view; the master modport   |
// |               is the view of whatever drives the pins and the tx stream.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface spi_target_sync_if;
    logic       CPOL;
    logic       CPHA;
    logic       sclk_pin;
    logic       mosi_pin;
    logic       cs_n_pin;
    logic       miso_pin;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       underrun;

    modport slave (
        input  CPOL, CPHA, sclk_pin, mosi_pin, cs_n_pin, tx_data, tx_valid,
        output miso_pin, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );

    modport master (
        output CPOL, CPHA, sclk_pin, mosi_pin, cs_n_pin, tx_data, tx_valid,
        input  miso_pin, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );
endinterface
`default_nettype wire

// File: rtl/spi_target_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_target_sync                                              |
// | Description : SPI target (slave), all four modes, oversampling the SPI     |
// |               pins with the system clock. One-byte tx holding register,    |
// |               back-to-back bytes under a single chip select.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_target_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_target_sync_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0] C_FILL_BYTE = 8'hFF;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_hist;
    logic                   r_mosi_hist;
    logic                   r_cs_hist;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_cpol;
    logic       r_cpha;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [6:0] r_rx_sr;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_underrun;

    logic w_sclk;
    logic w_cs;
    logic w_sclk_edge;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_leading;
    logic w_trailing;
    logic w_enter;
    logic w_leave;
    logic w_sample;
    logic w_shift;
    logic w_reload;
    logic w_load_shift;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_edge = (w_sclk != r_sclk_hist);
    assign w_cs_fall   = !w_cs && r_cs_hist;
    assign w_cs_rise   = w_cs && !r_cs_hist;
    // Leading edge leaves the latched idle level, trailing edge returns to it.
    assign w_leading   = w_sclk_edge && (w_sclk != r_cpol);
    assign w_trailing  = w_sclk_edge && (w_sclk == r_cpol);

    // Synchronizer chains plus one history flop per pin; idle-high reset so no false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '1;
            r_mosi_sync <= '1;
            r_cs_sync   <= '1;
            r_sclk_hist <= 1'b1;
            r_mosi_hist <= 1'b1;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sclk_sync[0] <= bus.sclk_pin;
            r_mosi_sync[0] <= bus.mosi_pin;
            r_cs_sync[0]   <= bus.cs_n_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
            end
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_mosi_hist <= r_mosi_sync[SYNC_STAGES-1];
            r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle actions; a chip-select edge masks any coincident sclk edge.
    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_leave      = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        w_reload     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_enter      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_leave      = 1'b1;
                end else begin
                    w_sample = r_cpha ? w_trailing : w_leading;
                    // The first shift edge of every byte (counter at 0) keeps the freshly
                    // loaded MSB on miso: in mode CPHA=0 it is the trailing edge right after
                    // the reload, in CPHA=1 it is the leading edge that opens the byte.
                    w_shift  = (r_cpha ? w_leading : w_trailing) && (r_cnt != 3'd0);
                    w_reload = w_sample && (r_cnt == 3'd7);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_load_shift = w_enter || w_reload;

    // Datapath: mode latch, bit counter, rx assembly, tx shift and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_cnt       <= 3'd0;
            r_shift     <= C_FILL_BYTE;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_rx_sr     <= 7'd0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            if (w_enter) begin
                r_cpol <= bus.CPOL;
                r_cpha <= bus.CPHA;
                r_cnt  <= 3'd0;
            end

            if (w_leave) begin
                r_cnt <= 3'd0;
            end

            if (w_sample) begin
                r_rx_sr <= {r_rx_sr[5:0], r_mosi_hist};
                r_cnt   <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_rx_data  <= {r_rx_sr, r_mosi_hist};
                    r_rx_valid <= 1'b1;
                end
            end

            if (w_load_shift) begin
                if (r_hold_full) begin
                    r_shift <= r_hold;
                end else begin
                    r_shift    <= C_FILL_BYTE;
                    r_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_shift <= {r_shift[6:0], 1'b1};
            end

            // A reload wins over a same-cycle write and leaves the holding register empty.
            if (w_load_shift) begin
                r_hold_full <= 1'b0;
            end else if (bus.tx_valid && !r_hold_full) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign bus.busy     = (r_state == ST_ACTIVE);
    assign bus.miso_oe  = (r_state == ST_ACTIVE);
    assign bus.miso_pin = (r_state == ST_ACTIVE) ? r_shift[7] : 1'b1;
    assign bus.tx_ready = !r_hold_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.underrun = r_underrun;

endmodule
`default_nettype wire
